// File: rtl/trap_unit_if.sv
// rtl/trap_unit_if.sv - write-back commit bus seen by the trap unit
interface trap_unit_if #(
  parameter int XLEN = 64
);
  logic            valid;
  logic            ready;
  logic            nop;
  logic [31:0]     ins;
  logic [XLEN-1:0] pc;

  modport master (output valid, ready, nop, ins, pc);
  modport slave  (input  valid, ready, nop, ins, pc);
endinterface

// File: rtl/trap_unit.sv
// rtl/trap_unit.sv - interrupt sync, trap/mret arbitration and CSR write set for write-back
module trap_unit #(
  parameter int XLEN        = 64,
  parameter int NUM_IRQ     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_MAX    = 255,
  parameter int CNT_W       = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ-1:0] i_irq,
  trap_unit_if.slave         wbu,
  input  logic [XLEN-1:0]    i_mie,
  input  logic [XLEN-1:0]    i_mstatus,
  input  logic [XLEN-1:0]    i_mtvec,
  input  logic [XLEN-1:0]    i_mepc,
  output logic [XLEN-1:0]    o_mip,
  output logic               o_kill,
  output logic               o_excp,
  output logic               o_intr,
  output logic [XLEN-1:0]    o_redirect_pc,
  output logic               o_mepc_wen,
  output logic [XLEN-1:0]    o_mepc_wdata,
  output logic               o_mcause_wen,
  output logic [XLEN-1:0]    o_mcause_wdata,
  output logic               o_mstatus_wen,
  output logic [XLEN-1:0]    o_mstatus_wdata,
  output logic [CNT_W-1:0]   o_trap_cnt
);

  localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INS_MRET   = 32'h3020_0073;

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t            state;
  logic [XLEN-1:0]   target_q;
  logic [HW-1:0]     hold_cnt;
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];

  logic              commit;
  logic              is_ecall, is_ebreak, is_mret;
  logic [XLEN-1:0]   act;
  logic [IW-1:0]     win_idx;
  logic [XLEN-2:0]   intr_code;
  logic              take_intr, take_ecall, take_ebreak, take_mret, trap_entry;
  logic [XLEN-1:0]   mst_entry, mst_mret;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= i_irq;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Source k lands on the machine-level cause slot 3+4k.
  always_comb begin
    o_mip = '0;
    for (int k = 0; k < NUM_IRQ; k++) o_mip[3+4*k] = sync_q[SYNC_STAGES-1][k];
  end

  assign commit    = wbu.valid & wbu.ready & ~wbu.nop & i_rst_n;
  assign is_ecall  = (wbu.ins == INS_ECALL);
  assign is_ebreak = (wbu.ins == INS_EBREAK);
  assign is_mret   = (wbu.ins == INS_MRET);
  assign act       = o_mip & i_mie;

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (act[3+4*k]) win_idx = IW'(k);
    end
  end

  assign intr_code   = {{(XLEN-3-IW){1'b0}}, win_idx, 2'b11};
  assign take_intr   = commit & i_mstatus[3] & (|act) & (state == S_IDLE);
  assign take_ecall  = commit & ~take_intr & is_ecall;
  assign take_ebreak = commit & ~take_intr & is_ebreak;
  assign take_mret   = commit & ~take_intr & is_mret;
  assign trap_entry  = take_intr | take_ecall | take_ebreak;

  always_comb begin
    mst_entry        = i_mstatus;
    mst_entry[12:11] = 2'b11;
    mst_entry[7]     = i_mstatus[3];
    mst_entry[3]     = 1'b0;
    mst_mret         = i_mstatus;
    mst_mret[12:11]  = 2'b00;
    mst_mret[7]      = 1'b1;
    mst_mret[3]      = i_mstatus[7];
  end

  always_comb begin
    o_intr          = take_intr;
    o_kill          = take_intr;
    o_excp          = take_ecall | take_ebreak | take_mret;
    o_redirect_pc   = '0;
    o_mepc_wen      = 1'b0;
    o_mepc_wdata    = '0;
    o_mcause_wen    = 1'b0;
    o_mcause_wdata  = '0;
    o_mstatus_wen   = 1'b0;
    o_mstatus_wdata = '0;
    if (trap_entry) begin
      o_redirect_pc   = i_mtvec;
      o_mepc_wen      = 1'b1;
      o_mepc_wdata    = wbu.pc;
      o_mcause_wen    = 1'b1;
      o_mstatus_wen   = 1'b1;
      o_mstatus_wdata = mst_entry;
    end else if (take_mret) begin
      o_redirect_pc   = i_mepc;
      o_mstatus_wen   = 1'b1;
      o_mstatus_wdata = mst_mret;
    end
    if (take_intr)        o_mcause_wdata = {1'b1, intr_code};
    else if (take_ecall)  o_mcause_wdata = XLEN'(11);
    else if (take_ebreak) o_mcause_wdata = XLEN'(3);
  end

  // HOLD keeps interrupts masked until the handler's first commit, an mret, or timeout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      target_q <= '0;
      hold_cnt <= '0;
    end else if (trap_entry) begin
      state    <= S_HOLD;
      target_q <= i_mtvec;
      hold_cnt <= '0;
    end else if (state == S_HOLD) begin
      if (take_mret || (commit && (wbu.pc == target_q)) || (hold_cnt == HOLD_LAST)) begin
        state <= S_IDLE;
      end else begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_trap_cnt <= '0;
    end else if (trap_entry && (o_trap_cnt != {CNT_W{1'b1}})) begin
      o_trap_cnt <= o_trap_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_trap_unit.sv
// tb/tb_trap_unit.sv - self-checking bench for trap_unit
module tb_trap_unit;
  localparam int XLEN = 64;
  localparam int NIRQ = 3;
  localparam int SYNC = 2;
  localparam int HMAX = 4;
  localparam int CW   = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_MRET   = 32'h3020_0073;
  localparam logic [31:0] I_NOP    = 32'h0000_0013;
  localparam logic [31:0] I_NEAR   = 32'h0000_0173;
  localparam logic [63:0] MTVEC    = 64'h8000_1000;
  localparam logic [63:0] PC0      = 64'h8000_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NIRQ-1:0] irq;
  logic [63:0] mie, mstatus, mtvec, mepc;
  logic [63:0] mip, redirect, mepc_wd, mcause_wd, mstatus_wd;
  logic kill, excp, intr, mepc_wen, mcause_wen, mstatus_wen;
  logic [CW-1:0] trap_cnt;

  trap_unit_if #(.XLEN(XLEN)) wbu ();

  trap_unit #(.XLEN(XLEN), .NUM_IRQ(NIRQ), .SYNC_STAGES(SYNC), .HOLD_MAX(HMAX), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_irq(irq), .wbu(wbu),
    .i_mie(mie), .i_mstatus(mstatus), .i_mtvec(mtvec), .i_mepc(mepc),
    .o_mip(mip), .o_kill(kill), .o_excp(excp), .o_intr(intr), .o_redirect_pc(redirect),
    .o_mepc_wen(mepc_wen), .o_mepc_wdata(mepc_wd), .o_mcause_wen(mcause_wen),
    .o_mcause_wdata(mcause_wd), .o_mstatus_wen(mstatus_wen), .o_mstatus_wdata(mstatus_wd),
    .o_trap_cnt(trap_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pending view is the irq level seen SYNC edges ago; HOLD tracked as elapsed cycles.
  logic        m_hold;
  logic [63:0] m_target;
  int          m_held, m_cnt, ncyc;
  logic [NIRQ-1:0] irq_log [256];

  typedef struct packed {
    logic commit, entry, mret, intr, kill, excp;
    logic [63:0] redirect;
    logic mepc_wen;   logic [63:0] mepc;
    logic cause_wen;  logic [63:0] cause;
    logic mst_wen;    logic [63:0] mst;
    logic [63:0] mip;
  } exp_t;

  function automatic exp_t model_calc();
    exp_t e;
    logic [63:0] a;
    logic [NIRQ-1:0] v;
    int win;
    e = '0;
    win = -1;
    v = (ncyc >= SYNC) ? irq_log[(ncyc - SYNC) % 256] : '0;
    for (int k = 0; k < NIRQ; k++) e.mip[3+4*k] = v[k];
    e.commit = wbu.valid && wbu.ready && !wbu.nop;
    a = e.mip & mie;
    if (e.commit && mstatus[3] && a != 0 && !m_hold) begin
      for (int j = NIRQ - 1; j >= 0; j--) if (win < 0 && a[3+4*j]) win = j;
      e.intr = 1; e.kill = 1; e.entry = 1;
      e.cause = 64'h8000_0000_0000_0000 + 64'(3 + 4 * win);
    end else if (e.commit && (wbu.ins == I_ECALL || wbu.ins == I_EBREAK)) begin
      e.excp = 1; e.entry = 1;
      e.cause = (wbu.ins == I_ECALL) ? 64'd11 : 64'd3;
    end else if (e.commit && wbu.ins == I_MRET) begin
      e.excp = 1; e.mret = 1; e.redirect = mepc; e.mst_wen = 1;
      e.mst = (mstatus & ~64'h1888) | 64'h80 | (mstatus[7] ? 64'h8 : 64'h0);
    end
    if (e.entry) begin
      e.redirect = mtvec; e.mepc_wen = 1; e.mepc = wbu.pc; e.cause_wen = 1; e.mst_wen = 1;
      e.mst = (mstatus & ~64'h1888) | 64'h1800 | (mstatus[3] ? 64'h80 : 64'h0);
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_upd
    exp_t e;
    if (!rst_n) begin
      m_hold <= 0; m_target <= '0; m_held <= 0; m_cnt <= 0; ncyc <= 0;
    end else begin
      e = model_calc();
      irq_log[ncyc % 256] <= irq;
      ncyc <= ncyc + 1;
      if (e.entry) begin
        m_hold <= 1; m_target <= mtvec; m_held <= 0;
        m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
      end else if (m_hold) begin
        if (e.mret || (e.commit && wbu.pc == m_target) || (m_held + 1 >= HMAX)) m_hold <= 0;
        m_held <= m_held + 1;
      end
    end
  end

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (rst_n) begin
      e = model_calc();
      chk("sb_intr", intr, e.intr);
      chk("sb_kill", kill, e.kill);
      chk("sb_excp", excp, e.excp);
      chk("sb_redirect", redirect, e.redirect);
      chk("sb_mepc_wen", mepc_wen, e.mepc_wen);
      chk("sb_mepc", mepc_wd, e.mepc);
      chk("sb_mcause_wen", mcause_wen, e.cause_wen);
      chk("sb_mcause", mcause_wd, e.cause);
      chk("sb_mstatus_wen", mstatus_wen, e.mst_wen);
      chk("sb_mstatus", mstatus_wd, e.mst);
      chk("sb_mip", mip, e.mip);
      chk("sb_cnt", trap_cnt, 64'(m_cnt));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    wbu.valid = 0; wbu.ready = 1; wbu.nop = 0; wbu.ins = I_NOP; wbu.pc = 64'h8000_0400;
  endtask

  task automatic commit_ins(input logic [31:0] ins, input logic [63:0] pc);
    wbu.valid = 1; wbu.ready = 1; wbu.nop = 0; wbu.ins = ins; wbu.pc = pc;
  endtask

  task automatic do_reset();
    rst_n = 0; cyc(); cyc(); rst_n = 1;
  endtask

  task automatic arm_irq(input logic [NIRQ-1:0] v, input logic [63:0] ie, input logic [63:0] st);
    do_reset();
    irq = v; mie = ie; mstatus = st; mtvec = MTVEC; mepc = PC0;
    idle_bus();
    cyc(); cyc(); cyc();
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_intr"}, intr, 0);          chk({tag, "_kill"}, kill, 0);
    chk({tag, "_excp"}, excp, 0);          chk({tag, "_redirect"}, redirect, 0);
    chk({tag, "_mepc_wen"}, mepc_wen, 0);  chk({tag, "_mepc"}, mepc_wd, 0);
    chk({tag, "_mcause_wen"}, mcause_wen, 0); chk({tag, "_mcause"}, mcause_wd, 0);
    chk({tag, "_mst_wen"}, mstatus_wen, 0);   chk({tag, "_mst"}, mstatus_wd, 0);
    chk({tag, "_mip"}, mip, 0);            chk({tag, "_cnt"}, trap_cnt, 0);
  endtask

  typedef struct {
    logic [NIRQ-1:0] irq; logic [63:0] mie; logic [63:0] mst; logic [31:0] ins;
    logic intr; logic excp; logic [63:0] redirect; logic cause_wen; logic [63:0] cause;
    logic [63:0] mst_w; int cnt;
  } vec_t;

  vec_t vt [11];

  initial begin
    vt[0]  = '{3'b010, 64'h80,  64'h8,    I_NOP,    1, 0, MTVEC, 1, 64'h8000_0000_0000_0007, 64'h1880, 1};
    vt[1]  = '{3'b101, 64'h888, 64'h8,    I_ECALL,  1, 0, MTVEC, 1, 64'h8000_0000_0000_000B, 64'h1880, 1};
    vt[2]  = '{3'b000, 64'h0,   64'h8,    I_ECALL,  0, 1, MTVEC, 1, 64'd11,                  64'h1880, 1};
    vt[3]  = '{3'b000, 64'h0,   64'h0,    I_EBREAK, 0, 1, MTVEC, 1, 64'd3,                   64'h1800, 1};
    vt[4]  = '{3'b000, 64'h0,   64'h1880, I_MRET,   0, 1, PC0,   0, 64'h0,                   64'h88,   0};
    vt[5]  = '{3'b010, 64'h80,  64'h0,    I_NOP,    0, 0, 64'h0, 0, 64'h0,                   64'h0,    0};
    vt[6]  = '{3'b010, 64'h8,   64'h8,    I_NOP,    0, 0, 64'h0, 0, 64'h0,                   64'h0,    0};
    vt[7]  = '{3'b000, 64'h0,   64'h8,    I_NEAR,   0, 0, 64'h0, 0, 64'h0,                   64'h0,    0};
    vt[8]  = '{3'b100, 64'h800, 64'h80,   I_EBREAK, 0, 1, MTVEC, 1, 64'd3,                   64'h1800, 1};
    vt[9]  = '{3'b000, 64'h0,   64'h1808, I_MRET,   0, 1, PC0,   0, 64'h0,                   64'h80,   0};
    vt[10] = '{3'b001, 64'h8,   64'h8,    I_MRET,   1, 0, MTVEC, 1, 64'h8000_0000_0000_0003, 64'h1880, 1};

    irq = '0; mie = '0; mstatus = '0; mtvec = MTVEC; mepc = PC0;
    idle_bus();
    #2;
    zero_outputs("reset");
    cyc(); rst_n = 1;

    for (int i = 0; i < 11; i++) begin
      arm_irq(vt[i].irq, vt[i].mie, vt[i].mst);
      commit_ins(vt[i].ins, PC0);
      @(negedge clk);
      chk($sformatf("vec%0d_intr", i), intr, vt[i].intr);
      chk($sformatf("vec%0d_kill", i), kill, vt[i].intr);
      chk($sformatf("vec%0d_excp", i), excp, vt[i].excp);
      chk($sformatf("vec%0d_redirect", i), redirect, vt[i].redirect);
      chk($sformatf("vec%0d_mcause_wen", i), mcause_wen, vt[i].cause_wen);
      chk($sformatf("vec%0d_mcause", i), mcause_wd, vt[i].cause);
      chk($sformatf("vec%0d_mepc_wen", i), mepc_wen, vt[i].cause_wen);
      chk($sformatf("vec%0d_mepc", i), mepc_wd, vt[i].cause_wen ? PC0 : 64'h0);
      chk($sformatf("vec%0d_mst_wen", i), mstatus_wen, vt[i].intr | vt[i].excp);
      chk($sformatf("vec%0d_mst", i), mstatus_wd, vt[i].mst_w);
      cyc(); idle_bus();
      @(negedge clk);
      chk($sformatf("vec%0d_cnt", i), trap_cnt, 64'(vt[i].cnt));
    end

    // synchroniser latency and an irq withdrawn before any commit
    do_reset();
    mie = 64'h80; mstatus = 64'h8; idle_bus(); irq = 3'b010;
    cyc(); @(negedge clk); chk("sync_1edge", mip, 64'h0);
    cyc(); @(negedge clk); chk("sync_2edge", mip, 64'h80);
    irq = 3'b000; cyc(); cyc();
    commit_ins(I_NOP, PC0); @(negedge clk); chk("withdrawn_intr", intr, 0);
    cyc();

    // re-entry mask until the handler's first commit
    arm_irq(3'b010, 64'h80, 64'h8);
    commit_ins(I_NOP, PC0); @(negedge clk); chk("reent_take", intr, 1);
    cyc(); commit_ins(I_NOP, PC0 + 4); @(negedge clk); chk("reent_mask1", intr, 0);
    cyc(); commit_ins(I_NOP, PC0 + 8); @(negedge clk); chk("reent_mask2", intr, 0);
    cyc(); commit_ins(I_NOP, MTVEC);   @(negedge clk); chk("reent_target", intr, 0);
    cyc(); commit_ins(I_NOP, MTVEC + 4); @(negedge clk); chk("reent_retake", intr, 1);
    cyc(); idle_bus();

    // hold timeout with no commits
    arm_irq(3'b010, 64'h80, 64'h8);
    commit_ins(I_NOP, PC0); @(negedge clk); chk("tmo_take", intr, 1);
    cyc(); idle_bus(); cyc(); cyc(); cyc();
    commit_ins(I_NOP, 64'h8000_0300); @(negedge clk); chk("tmo_still_hold", intr, 0);
    cyc(); commit_ins(I_NOP, 64'h8000_0304); @(negedge clk); chk("tmo_retake", intr, 1);
    cyc(); idle_bus();

    // counter saturation
    arm_irq(3'b000, 64'h0, 64'h8);
    for (int n = 0; n < 5; n++) begin
      commit_ins(I_ECALL, PC0 + 64'(4 * n)); cyc();
    end
    idle_bus(); @(negedge clk); chk("cnt_sat", trap_cnt, 64'd3);
    cyc();

    // async reset while in HOLD
    arm_irq(3'b010, 64'h80, 64'h8);
    commit_ins(I_NOP, PC0); @(negedge clk); chk("arst_take", intr, 1);
    cyc(); commit_ins(I_NOP, 64'h8000_0200);
    #2 rst_n = 0;
    #1 zero_outputs("arst");
    cyc(); rst_n = 1; idle_bus();
    cyc(); cyc(); cyc();
    commit_ins(I_NOP, 64'h8000_0200); @(negedge clk); chk("arst_retake", intr, 1);
    cyc(); idle_bus();

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) irq = NIRQ'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: mie = 64'h888;
          1: mie = 64'h80;
          2: mie = 64'h0;
          default: mie = {$urandom, $urandom};
        endcase
      end
      case ($urandom_range(0, 4))
        0: mstatus = 64'h8;
        1: mstatus = 64'h0;
        2: mstatus = 64'h1880;
        3: mstatus = 64'h1888;
        default: mstatus = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 31) == 0) mtvec = ($urandom_range(0, 1) == 0) ? MTVEC : 64'h8000_2000;
      mepc = {32'h0, $urandom};
      wbu.valid = ($urandom_range(0, 3) != 0);
      wbu.ready = ($urandom_range(0, 3) != 0);
      wbu.nop   = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 7))
        0: wbu.ins = I_ECALL;
        1: wbu.ins = I_EBREAK;
        2: wbu.ins = I_MRET;
        3: wbu.ins = I_NEAR;
        default: wbu.ins = I_NOP;
      endcase
      wbu.pc = ($urandom_range(0, 2) == 0) ? mtvec : {32'h0, $urandom};
      cyc();
    end

    idle_bus();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
